seq_divider59_26: RTL

SEQ_DIVIDER59_26 -- requirements
Module: seq_divider59_26

---
 rtl/seq_div_pkg.sv | 29 ++
 rtl/seq_div_step.sv | 32 +++
 rtl/seq_divider59_26.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_pkg
//  Description : Shared defaults, iteration counts and state encoding for the
//                sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_div_pkg;

    // Default operand widths of the divider.
    localparam int c_dividend_w  = 59;
    localparam int c_divisor_w   = 26;

    // RUN-state cycle counts for the default dividend width: one quotient bit
    // per cycle, or two per cycle with the dividend padded to an even width.
    localparam int c_iter_radix2 = 59;
    localparam int c_iter_radix4 = 30;

    // Width of the iteration down-counter.
    localparam int c_cnt_w       = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder and subtracts the
//                divisor when that does not borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_div_step #(
    parameter int DIVISOR_W = 26
) (
    input  logic [DIVISOR_W-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_rem,
    output logic                 o_q_bit
);

    logic [DIVISOR_W:0] w_partial;
    logic [DIVISOR_W:0] w_sub;

    // Compare-and-subtract; the incoming remainder is below the divisor, so
    // the result always fits back into DIVISOR_W bits.
    always_comb begin
        w_partial = {i_rem, i_bit};
        o_q_bit   = (w_partial >= {1'b0, i_divisor});
        w_sub     = o_q_bit ? {1'b0, i_divisor} : '0;
        o_rem     = DIVISOR_W'(w_partial - w_sub);
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider59_26.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider59_26
//  Description : Sequential unsigned restoring divider (59-bit dividend,
//                26-bit divisor), MSB first. Divide-by-zero is reported in two
//                cycles without iterating.
//                Define SEQ_DIV_RADIX4_EN to retire two quotient bits per
//                cycle (dividend zero-extended to an even width).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider59_26
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = c_dividend_w,
    parameter int DIVISOR_W  = c_divisor_w
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

`ifdef SEQ_DIV_RADIX4_EN
    localparam int c_radix_bits = 2;
    localparam int c_iter       = c_iter_radix4;
`else
    localparam int c_radix_bits = 1;
    localparam int c_iter       = c_iter_radix2;
`endif
    // Working quotient register width: the dividend, padded when needed so
    // that every iteration consumes exactly c_radix_bits bits.
    localparam int                 c_q_w      = c_iter * c_radix_bits;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_iter - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_busy;

    logic [c_q_w-1:0]       r_q;
    logic [DIVISOR_W-1:0]   r_rem;
    logic [DIVISOR_W-1:0]   r_divisor;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_div_zero;
    logic                   r_done;

    logic [c_q_w-1:0]       w_q_next;
    logic [DIVISOR_W-1:0]   w_rem_next;
    logic [DIVISOR_W-1:0]   w_rem_a;
    logic                   w_qb_a;

    // First (or only) conditional-subtract stage, fed by the dividend MSB.
    seq_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step_a (
        .i_rem     (r_rem),
        .i_bit     (r_q[c_q_w-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_a),
        .o_q_bit   (w_qb_a)
    );

`ifdef SEQ_DIV_RADIX4_EN
    logic [DIVISOR_W-1:0]   w_rem_b;
    logic                   w_qb_b;

    // Second chained stage consumes the next dividend bit in the same cycle.
    seq_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step_b (
        .i_rem     (w_rem_a),
        .i_bit     (r_q[c_q_w-2]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_b),
        .o_q_bit   (w_qb_b)
    );

    assign w_rem_next = w_rem_b;
    assign w_q_next   = {r_q[c_q_w-3:0], w_qb_a, w_qb_b};
`else
    assign w_rem_next = w_rem_a;
    assign w_q_next   = {r_q[c_q_w-2:0], w_qb_a};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and busy flag.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (divisor == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and done pulse. The quotient shift
    // register starts out holding the dividend; each RUN cycle shifts dividend
    // bits out at the top and quotient bits in at the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q        <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_divisor <= divisor;
                        r_cnt     <= c_cnt_load;
                        if (divisor == '0) begin
                            r_q        <= '1;
                            r_rem      <= dividend[DIVISOR_W-1:0];
                            r_div_zero <= 1'b1;
                        end else begin
                            r_q        <= c_q_w'(dividend);
                            r_rem      <= '0;
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_q    <= w_q_next;
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt - 1'b1;
                    r_done <= (r_cnt == '0);
                end
                ST_DONE: begin
                    // Divide-by-zero results were written at acceptance; the
                    // pulse is raised on the way out of DONE.
                    r_done <= r_div_zero;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = w_busy;
    assign done      = r_done;
    assign quotient  = r_q[DIVIDEND_W-1:0];
    assign remainder = r_rem;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire
